seq_multiplier_n: RTL and testbench
===================================

Name: seq_multiplier_n

Overview:
Parametrised iterative shift-add multiplier. It is the next generation of the lab's 8-bit switch-driven multiplier: generic width, signed/unsigned mode, and a start/busy/done handshake in place of push-button sequencing. It sits behind the synchronizers in a top level, or under a bus wrapper, and produces a full 2*WIDTH-bit product. It has one clock, and each iteration does one add step and one shift step in a single cycle.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  reset, asynchronous assert, active-low
Start  input  1  request a multiply; sampled only in IDLE or DONE
Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
A_in  input  WIDTH  multiplicand; sampled with Start
B_in  input  WIDTH  multiplier; sampled with Start
Busy  output  1  high in RUN (and ACC if compiled in)
Done  output  1  one-cycle pulse when Product becomes valid
Product  output  2*WIDTH  result; holds until the next accepted Start or reset

Behaviour:
- Reset (Reset_n=0, async):
  - FSM goes to IDLE.
  - M, A, B, X, count, Product, Busy and Done all clear to 0.
  - Reset asserted mid-RUN aborts the operation; no Done is issued.
- Internal registers:
  - M (WIDTH): latched multiplicand.
  - A (WIDTH): upper accumulator.
  - B (WIDTH): multiplier, shifted.
  - X (1): sign/extension bit.
  - count (CNT_W).
  - mode (1): latched Signed_Mode.
- States: IDLE, RUN, DONE.
- IDLE/DONE, Start=1:
  - Load M<=A_in, B<=B_in, A<=0, X<=0, count<=0, mode<=Signed_Mode.
  - Next state RUN. Busy=1 from the next cycle.
- RUN, each cycle:
  - If B[0]=1, S = {ext(A)} +/- {ext(M)} as a WIDTH+1-bit operation, else S={X,A}.
  - ext is sign-extension when mode=1, zero-extension when mode=0.
  - Subtract only when mode=1, B[0]=1 and count==WIDTH-1 (weight of the sign bit). Otherwise add.
  - Shift right: {X,A,B} <= {S[WIDTH] (mode=1) or 0 (mode=0), S[WIDTH:0], B[WIDTH-1:1]}.
    - In unsigned mode the carry S[WIDTH] shifts into A[WIDTH-1]; X stays 0.
  - count <= count+1. When count==WIDTH-1, next state is DONE.
- Entry to DONE:
  - Product <= {A,B} (after the final shift).
  - Done=1 for exactly that one cycle. Busy=0.
- DONE with no Start: return to IDLE the next cycle.
- Latency:
  - Start accepted at cycle 0 gives Done at cycle WIDTH+1.
  - Back-to-back Start in the Done cycle is accepted, giving a throughput of one result per WIDTH+1 cycles.
- Start while Busy=1 is ignored; operand changes during RUN have no effect.
- Product is exact modulo 2^(2*WIDTH). Signed results are two's complement; no overflow is possible.
- Boundaries:
  - Operand 0 gives product 0.
  - The signed minimum times itself is exact: WIDTH=8, -128*-128 = 0x4000.

Optional Feature:
Macro MULT_ACC_EN.
- Defined:
  - Adds input port Acc (1 bit), sampled with Start, and state ACC between RUN and DONE.
  - When Acc=1, ACC sets Product <= Product + {A,B} (wraps mod 2^(2*WIDTH)).
  - When Acc=0, ACC sets Product <= {A,B}.
  - Busy stays high in ACC; latency becomes WIDTH+2.
- Undefined:
  - No Acc port and no ACC state; behaviour is exactly as above.

Test Plan:
1. WIDTH=8, unsigned, A_in=0xFF, B_in=0xFF, Start -> Done at cycle 9, Product=0xFE01.
2. Signed, A_in=0x07, B_in=0xFD (-3) -> Product=0xFFEB (-21). Signed 0x80*0x80 -> 0x4000. Signed 0xFF*0xFF -> 0x0001.
3. Unsigned 0x80*0x80 -> 0x4000. Unsigned 0x00*0xA5 -> 0x0000, with Done still at cycle 9.
4. Start, then pulse Start again at cycle 3 with new operands -> second request ignored, single Done, Product from the first operands. Start held during Done -> new operation accepted, Busy high next cycle.
5. Reset_n low at cycle 4 of RUN -> all outputs 0 immediately, no Done. After release, 0x0C*0x0A -> 0x0078.
6. MULT_ACC_EN: 3*4 with Acc=0, then 5*6 with Acc=1 -> Products 0x000C then 0x002A. Done at cycle 10 each.

Source files
------------

// File: rtl/seq_multiplier_n_if.sv
`default_nettype none
// seq_multiplier_n_if: start/busy/done handshake and operand/result bus for seq_multiplier_n.
// Carries the Acc request bit only when MULT_ACC_EN is defined.
interface seq_multiplier_n_if #(
   parameter int WIDTH = 8
);
   logic                 Start;
   logic                 Signed_Mode;
   logic [WIDTH-1:0]     A_in;
   logic [WIDTH-1:0]     B_in;
`ifdef MULT_ACC_EN
   logic                 Acc;
`endif
   logic                 Busy;
   logic                 Done;
   logic [2*WIDTH-1:0]   Product;

   modport master (
`ifdef MULT_ACC_EN
      output Acc,
`endif
      output Start, Signed_Mode, A_in, B_in,
      input  Busy, Done, Product
   );

   modport slave (
`ifdef MULT_ACC_EN
      input  Acc,
`endif
      input  Start, Signed_Mode, A_in, B_in,
      output Busy, Done, Product
   );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier_n.sv
`default_nettype none
// seq_multiplier_n: iterative shift-add multiplier (signed/unsigned), one add+shift per cycle.
// Optional MULT_ACC_EN adds an Acc input and an ACC state that accumulates into Product.
module seq_multiplier_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   seq_multiplier_n_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
`ifdef MULT_ACC_EN
      ACC  = 2'd3,
`endif
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 x_q, x_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef MULT_ACC_EN
   logic                 acc_q, acc_d;
`endif

   logic [WIDTH:0]       ext_a;
   logic [WIDTH:0]       ext_m;
   logic [WIDTH:0]       sum;
   logic                 last;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      a_d       = a_q;
      b_d       = b_q;
      x_d       = x_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      product_d = product_q;
`ifdef MULT_ACC_EN
      acc_d     = acc_q;
`endif
      ext_a = {mode_q & a_q[WIDTH-1], a_q};
      ext_m = {mode_q & m_q[WIDTH-1], m_q};
      last  = (cnt_q == CNT_W'(WIDTH - 1));
      // The sign bit of a two's-complement multiplier carries negative weight.
      if (b_q[0]) begin
         if (mode_q && last) begin
            sum = ext_a - ext_m;
         end else begin
            sum = ext_a + ext_m;
         end
      end else begin
         sum = {x_q, a_q};
      end

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.Start) begin
               m_d     = bus.A_in;
               b_d     = bus.B_in;
               a_d     = '0;
               x_d     = 1'b0;
               cnt_d   = '0;
               mode_d  = bus.Signed_Mode;
`ifdef MULT_ACC_EN
               acc_d   = bus.Acc;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            x_d   = mode_q & sum[WIDTH];
            a_d   = sum[WIDTH:1];
            b_d   = {sum[0], b_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
`ifdef MULT_ACC_EN
               state_d   = ACC;
`else
               product_d = {a_d, b_d};
               state_d   = DONE;
`endif
            end
         end
`ifdef MULT_ACC_EN
         ACC: begin
            product_d = acc_q ? (product_q + {a_q, b_q}) : {a_q, b_q};
            state_d   = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         x_q       <= 1'b0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         product_q <= '0;
`ifdef MULT_ACC_EN
         acc_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         a_q       <= a_d;
         b_q       <= b_d;
         x_q       <= x_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         product_q <= product_d;
`ifdef MULT_ACC_EN
         acc_q     <= acc_d;
`endif
      end
   end

`ifdef MULT_ACC_EN
   assign bus.Busy = (state_q == RUN) || (state_q == ACC);
`else
   assign bus.Busy = (state_q == RUN);
`endif
   assign bus.Done    = (state_q == DONE);
   assign bus.Product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_n.sv
`default_nettype none
// tb_seq_multiplier_n: directed vectors and handshake/reset sequences for seq_multiplier_n (WIDTH=8).
module tb_seq_multiplier_n;
   localparam int W = 8;
`ifdef MULT_ACC_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sgn;
      logic [2*W-1:0] exp;
      string          name;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset_n;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[13];

   seq_multiplier_n_if #(.WIDTH(W)) intf ();
   seq_multiplier_n #(.WIDTH(W)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (intf)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input logic acc);
      intf.A_in        = a;
      intf.B_in        = b;
      intf.Signed_Mode = sgn;
`ifdef MULT_ACC_EN
      intf.Acc         = acc;
`else
      if (acc) $display("note: acc request ignored in this build");
`endif
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic acc, input logic [2*W-1:0] exp, input string name);
      int   done_at = -1;
      logic busy_ok = 1'b1;
      @(negedge Clk);
      drive(a, b, sgn, acc);
      intf.Start = 1'b1;
      for (int n = 1; n <= LAT + 4; n++) begin
         @(posedge Clk); #1;
         intf.Start = 1'b0;
         if (intf.Done) begin
            done_at = n;
            break;
         end
         if (!intf.Busy) busy_ok = 1'b0;
      end
      chk({name, " latency"}, 32'(done_at), 32'(LAT));
      chk({name, " busy_run"}, 32'(busy_ok), 32'd1);
      chk({name, " product"}, 32'(intf.Product), 32'(exp));
      chk({name, " busy_at_done"}, 32'(intf.Busy), 32'd0);
      @(posedge Clk); #1;
      chk({name, " done_pulse"}, 32'(intf.Done), 32'd0);
   endtask

   initial begin
      int             dat;
      int             dcount;
      logic [2*W-1:0] prod;

      vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff"};
      vecs[1]  = '{8'h07, 8'hFD, 1'b1, 16'hFFEB, "s_07_fd"};
      vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80"};
      vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff"};
      vecs[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80"};
      vecs[5]  = '{8'h00, 8'hA5, 1'b0, 16'h0000, "u_00_a5"};
      vecs[6]  = '{8'h0C, 8'h0A, 1'b0, 16'h0078, "u_0c_0a"};
      vecs[7]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s_7f_80"};
      vecs[8]  = '{8'h7F, 8'h80, 1'b0, 16'h3F80, "u_7f_80"};
      vecs[9]  = '{8'h00, 8'h80, 1'b1, 16'h0000, "s_00_80"};
      vecs[10] = '{8'hFD, 8'h07, 1'b1, 16'hFFEB, "s_fd_07"};
      vecs[11] = '{8'h0D, 8'h0B, 1'b0, 16'h008F, "u_0d_0b"};
      vecs[12] = '{8'h03, 8'h04, 1'b0, 16'h000C, "u_03_04"};

      Reset_n    = 1'b0;
      intf.Start = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge Clk);
      #1;
      chk("reset busy", 32'(intf.Busy), 32'd0);
      chk("reset done", 32'(intf.Done), 32'd0);
      chk("reset product", 32'(intf.Product), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, vecs[i].exp, vecs[i].name);
      end

      // A second Start mid-operation must be ignored.
      @(negedge Clk);
      drive(8'h05, 8'h06, 1'b0, 1'b0);
      intf.Start = 1'b1;
      dat = -1;
      dcount = 0;
      prod = '0;
      for (int n = 1; n <= LAT + 4; n++) begin
         @(posedge Clk); #1;
         if (n == 1) intf.Start = 1'b0;
         if (n == 3) begin
            drive(8'hFF, 8'hFF, 1'b1, 1'b0);
            intf.Start = 1'b1;
         end
         if (n == 4) intf.Start = 1'b0;
         if (intf.Done) begin
            dcount++;
            if (dat < 0) begin
               dat  = n;
               prod = intf.Product;
            end
         end
      end
      chk("midrun done_count", 32'(dcount), 32'd1);
      chk("midrun latency", 32'(dat), 32'(LAT));
      chk("midrun product", 32'(prod), 32'h001E);

      // Back-to-back: Start held during the Done cycle.
      @(negedge Clk);
      drive(8'h02, 8'h03, 1'b0, 1'b0);
      intf.Start = 1'b1;
      dat = -1;
      for (int n = 1; n <= LAT + 4; n++) begin
         @(posedge Clk); #1;
         intf.Start = 1'b0;
         if (intf.Done) begin
            dat = n;
            break;
         end
      end
      chk("b2b first latency", 32'(dat), 32'(LAT));
      chk("b2b first product", 32'(intf.Product), 32'h0006);
      drive(8'h04, 8'h05, 1'b0, 1'b0);
      intf.Start = 1'b1;
      @(posedge Clk); #1;
      intf.Start = 1'b0;
      chk("b2b busy next", 32'(intf.Busy), 32'd1);
      chk("b2b done next", 32'(intf.Done), 32'd0);
      dat = -1;
      for (int n = 2; n <= LAT + 4; n++) begin
         @(posedge Clk); #1;
         if (intf.Done) begin
            dat = n;
            break;
         end
      end
      chk("b2b second latency", 32'(dat), 32'(LAT));
      chk("b2b second product", 32'(intf.Product), 32'h0014);

      // Asynchronous reset in the middle of RUN.
      @(negedge Clk);
      drive(8'hFF, 8'hFF, 1'b0, 1'b0);
      intf.Start = 1'b1;
      @(posedge Clk); #1;
      intf.Start = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("abort product", 32'(intf.Product), 32'd0);
      chk("abort busy", 32'(intf.Busy), 32'd0);
      chk("abort done", 32'(intf.Done), 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      dcount = 0;
      for (int n = 0; n < LAT + 3; n++) begin
         @(posedge Clk); #1;
         if (intf.Done || intf.Busy) dcount++;
      end
      chk("abort no_done", 32'(dcount), 32'd0);
      run_op(8'h0C, 8'h0A, 1'b0, 1'b0, 16'h0078, "after_reset");

`ifdef MULT_ACC_EN
      run_op(8'h03, 8'h04, 1'b0, 1'b0, 16'h000C, "acc0_3x4");
      run_op(8'h05, 8'h06, 1'b0, 1'b1, 16'h002A, "acc1_5x6");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
